sun_pll_lock_ctrl: RTL

- Digital power-up sequencer and lock detector for the SUN PLL, clocked by the reference clock.
- Sits upstream of the PLL core: drives its PWRUP_1V8, then consumes a slowed copy of the divider feedback clock CK_FB.
- Declares LOCK when the feedback edge count per window matches the expected value, and FAIL if lock is not reached within a timeout.

---
 rtl/sun_pll_lock_ctrl_if.sv | 27 ++
 rtl/sun_pll_lock_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sun_pll_lock_ctrl_if.sv
// Control/status bundle between the SUN PLL lock controller and its environment.
// The enable, the slowed feedback clock and all status outputs travel here;
// the reference clock and reset stay plain ports on the controller.
interface sun_pll_lock_ctrl_if #(
  parameter int WIN_LOG2 = 8
);
  logic                en;
  logic                fb_slow;
  logic                pwrup_1v8;
  logic                lock;
  logic                fail;
  logic [2:0]          state;
  logic [WIN_LOG2-1:0] fb_cnt;
  logic                cnt_vld;

  // Environment side: drives enable and feedback, observes status.
  modport master (
    output en, fb_slow,
    input  pwrup_1v8, lock, fail, state, fb_cnt, cnt_vld
  );

  // Controller side.
  modport slave (
    input  en, fb_slow,
    output pwrup_1v8, lock, fail, state, fb_cnt, cnt_vld
  );
endinterface

// File: rtl/sun_pll_lock_ctrl.sv
// SUN PLL power-up sequencer and lock detector, clocked by the reference clock.
// Powers the PLL, waits a settle time, then measures the slowed feedback clock
// over fixed windows and declares lock (or an acquisition timeout).
//
// Status handshake: cnt_vld is a one-cycle valid strobe with no ready; fb_cnt
// is stable from that strobe until the next one and a consumer that is not
// looking simply misses the strobe (there is no backpressure).
module sun_pll_lock_ctrl #(
  parameter int SETTLE_CYC = 1024,
  parameter int WIN_LOG2   = 8,
  parameter int EXP_CNT    = 32,
  parameter int TOL        = 1,
  parameter int LOCK_WIN   = 4,
  parameter int UNLOCK_WIN = 2,
  parameter int MAX_WIN    = 64
) (
  input  logic                 ck_ref,
  input  logic                 rst,
  sun_pll_lock_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_ACQ    = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int GOOD_W = $clog2(LOCK_WIN + 1);
  localparam int BAD_W  = $clog2(UNLOCK_WIN + 1);
  localparam int TOT_W  = $clog2(MAX_WIN + 1);

  localparam logic [WIN_LOG2-1:0] CNT_MAX     = '1;
  localparam logic [WIN_LOG2-1:0] EXP_V       = WIN_LOG2'(EXP_CNT);
  localparam logic [WIN_LOG2-1:0] TOL_V       = WIN_LOG2'(TOL);
  localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [GOOD_W-1:0]   LOCK_N      = GOOD_W'(LOCK_WIN);
  localparam logic [BAD_W-1:0]    UNLOCK_N    = BAD_W'(UNLOCK_WIN);
  localparam logic [TOT_W-1:0]    MAX_N       = TOT_W'(MAX_WIN);

  state_t              state;
  logic                sync1, sync2, sync3;
  logic [SET_W-1:0]    settle_cnt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2-1:0] edge_cnt;
  logic [GOOD_W-1:0]   good_cnt;
  logic [BAD_W-1:0]    bad_cnt;
  logic [TOT_W-1:0]    tot_cnt;
  logic                pwrup_q, lock_q, fail_q, cnt_vld_q;
  logic [WIN_LOG2-1:0] fb_cnt_q;

  logic                fb_edge;
  logic [WIN_LOG2-1:0] edge_next;
  logic                win_last;
  logic [WIN_LOG2-1:0] dev;
  logic                win_good;
  logic [GOOD_W-1:0]   good_next;
  logic [BAD_W-1:0]    bad_next;
  logic [TOT_W-1:0]    tot_next;

  // Bring the asynchronous feedback into ck_ref; sync3 only serves edge detection.
  always_ff @(posedge ck_ref) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.fb_slow;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Edge detect, saturating window count and good/bad window classification.
  always_comb begin
    fb_edge   = sync2 & ~sync3;
    edge_next = edge_cnt;
    if (fb_edge && (edge_cnt != CNT_MAX)) begin
      edge_next = edge_cnt + 1'b1;
    end
    win_last = (win_cnt == CNT_MAX);
    dev      = (edge_next >= EXP_V) ? (edge_next - EXP_V) : (EXP_V - edge_next);
    win_good = (dev <= TOL_V);
    good_next = win_good ? (good_cnt + 1'b1) : '0;
    bad_next  = win_good ? '0 : (bad_cnt + 1'b1);
    tot_next  = tot_cnt + 1'b1;
  end

  // Sequencer FSM with its counters and registered status outputs.
  always_ff @(posedge ck_ref) begin
    if (rst) begin
      state      <= ST_OFF;
      settle_cnt <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      tot_cnt    <= '0;
      pwrup_q    <= 1'b0;
      lock_q     <= 1'b0;
      fail_q     <= 1'b0;
      cnt_vld_q  <= 1'b0;
      fb_cnt_q   <= '0;
    end else begin
      cnt_vld_q <= 1'b0;
      if (!bus.en) begin
        // Disable wins over everything; the last measurement is kept for software.
        state      <= ST_OFF;
        settle_cnt <= '0;
        win_cnt    <= '0;
        edge_cnt   <= '0;
        good_cnt   <= '0;
        bad_cnt    <= '0;
        tot_cnt    <= '0;
        pwrup_q    <= 1'b0;
        lock_q     <= 1'b0;
        fail_q     <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            state      <= ST_PWRUP;
            pwrup_q    <= 1'b1;
            settle_cnt <= '0;
          end
          ST_PWRUP: begin
            if (settle_cnt == SETTLE_LAST) begin
              state      <= ST_ACQ;
              settle_cnt <= '0;
              win_cnt    <= '0;
              edge_cnt   <= '0;
              good_cnt   <= '0;
              bad_cnt    <= '0;
              tot_cnt    <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_ACQ, ST_LOCKED: begin
            // Window counter wraps naturally, so every window boundary restarts it.
            win_cnt <= win_cnt + 1'b1;
            if (win_last) begin
              fb_cnt_q  <= edge_next;
              cnt_vld_q <= 1'b1;
              edge_cnt  <= '0;
              if (state == ST_ACQ) begin
                tot_cnt  <= tot_next;
                good_cnt <= good_next;
                if (good_next == LOCK_N) begin
                  state    <= ST_LOCKED;
                  lock_q   <= 1'b1;
                  good_cnt <= '0;
                  bad_cnt  <= '0;
                  tot_cnt  <= '0;
                end else if (tot_next == MAX_N) begin
                  state  <= ST_FAIL;
                  fail_q <= 1'b1;
                end
              end else begin
                bad_cnt <= bad_next;
                if (bad_next == UNLOCK_N) begin
                  state    <= ST_ACQ;
                  lock_q   <= 1'b0;
                  good_cnt <= '0;
                  bad_cnt  <= '0;
                  tot_cnt  <= '0;
                end
              end
            end else begin
              edge_cnt <= edge_next;
            end
          end
          ST_FAIL: begin
            // Timeout is sticky until the enable is dropped.
            state <= ST_FAIL;
          end
          default: begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            tot_cnt    <= '0;
            pwrup_q    <= 1'b0;
            lock_q     <= 1'b0;
            fail_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.state     = state;
  assign bus.pwrup_1v8 = pwrup_q;
  assign bus.lock      = lock_q;
  assign bus.fail      = fail_q;
  assign bus.fb_cnt    = fb_cnt_q;
  assign bus.cnt_vld   = cnt_vld_q;

endmodule
